// File: rtl/dmem_responder_pkg.sv
// =============================================================================
// Module  : dmem_responder_pkg
// Brief   : Shared MIPS control constants plus data-memory size/type and FSM
//           encodings.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2B;

    localparam logic [1:0] c_WR_WORD = 2'b00;
    localparam logic [1:0] c_WR_HALF = 2'b01;
    localparam logic [1:0] c_WR_BYTE = 2'b10;
    localparam logic [1:0] c_WR_NONE = 2'b11;

    localparam logic [2:0] c_RD_WORD   = 3'b000;
    localparam logic [2:0] c_RD_HALF_S = 3'b001;
    localparam logic [2:0] c_RD_HALF_U = 3'b010;
    localparam logic [2:0] c_RD_BYTE_S = 3'b011;
    localparam logic [2:0] c_RD_BYTE_U = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DONE = 1'b1
    } memState_t;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// =============================================================================
// Module  : dmem_responder_if
// Brief   : CPU memory-stage to data-memory bus.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [1:0]  DMwrite_ctrl;
    logic [2:0]  DMread_ctrl;
    logic [31:0] readdataM;
    logic        mem_stall;
    logic        adelM;
    logic        adesM;

    modport master (
        output memwriteM, memreadM, aluoutM, writedataM, DMwrite_ctrl, DMread_ctrl,
        input  readdataM, mem_stall, adelM, adesM
    );

    modport slave (
        input  memwriteM, memreadM, aluoutM, writedataM, DMwrite_ctrl, DMread_ctrl,
        output readdataM, mem_stall, adelM, adesM
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ram.sv
// =============================================================================
// Module  : dmem_ram
// Brief   : Byte-enabled synchronous single-port RAM with registered read.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_ram #(
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [3:0]        i_we,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output logic      [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // Storage is intentionally never reset; only the read register is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'h0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder: sub-word stores, one-stall loads, alignment.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    dmem_responder_if.slave     bus
);

    memState_t          r_state;
    memState_t          w_nextState;
    logic [2:0]         r_rdType;
    logic [1:0]         r_rdLane;
    logic [ADDR_W-1:0]  w_idx;
    logic [1:0]         w_lane;
    logic               w_storeMis;
    logic               w_loadMis;
    logic [3:0]         w_wrMask;
    logic [3:0]         w_we;
    logic               w_re;
    logic               w_stall;
    logic               w_adel;
    logic               w_ades;
    logic [31:0]        w_wdata;
    logic [31:0]        w_ramQ;
    logic [31:0]        w_ext;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_unusedAddrHi;

    assign w_idx          = bus.aluoutM[ADDR_W+1:2];
    assign w_lane         = bus.aluoutM[1:0];
    assign w_unusedAddrHi = ^bus.aluoutM[31:ADDR_W+2];

    always_comb begin
        w_storeMis = 1'b0;
        w_wrMask   = 4'b0000;
        w_wdata    = bus.writedataM;
        case (bus.DMwrite_ctrl)
            c_WR_WORD: begin
                w_storeMis = |w_lane;
                w_wrMask   = 4'b1111;
            end
            c_WR_HALF: begin
                w_storeMis = w_lane[0];
                w_wrMask   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.writedataM[15:0]}};
            end
            c_WR_BYTE: begin
                w_wrMask   = 4'b0001 << w_lane;
                w_wdata    = {4{bus.writedataM[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.DMread_ctrl)
            c_RD_HALF_S, c_RD_HALF_U: w_loadMis = w_lane[0];
            c_RD_BYTE_S, c_RD_BYTE_U: w_loadMis = 1'b0;
            default:                  w_loadMis = |w_lane;
        endcase
    end

    // Simultaneous read and write is a store; requests held during RD_DONE are ignored.
    always_comb begin
        w_nextState = r_state;
        w_we        = 4'b0000;
        w_re        = 1'b0;
        w_stall     = 1'b0;
        w_adel      = 1'b0;
        w_ades      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst) begin
                    if (bus.memwriteM) begin
                        if (w_storeMis) w_ades = 1'b1;
                        else            w_we   = w_wrMask;
                    end else if (bus.memreadM) begin
                        if (w_loadMis) begin
                            w_adel = 1'b1;
                        end else begin
                            w_re        = 1'b1;
                            w_stall     = 1'b1;
                            w_nextState = ST_RD_DONE;
                        end
                    end
                end
            end
            ST_RD_DONE: w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rdType <= c_RD_WORD;
            r_rdLane <= 2'b00;
        end else begin
            r_state <= w_nextState;
            if (w_re) begin
                r_rdType <= bus.DMread_ctrl;
                r_rdLane <= w_lane;
            end
        end
    end

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_ramQ)
    );

    // The RAM read register only moves on an accepted load, so this holds the last result.
    always_comb begin
        w_byte = w_ramQ[{r_rdLane, 3'b000} +: 8];
        w_half = r_rdLane[1] ? w_ramQ[31:16] : w_ramQ[15:0];
        case (r_rdType)
            c_RD_HALF_S: w_ext = {{16{w_half[15]}}, w_half};
            c_RD_HALF_U: w_ext = {16'h0, w_half};
            c_RD_BYTE_S: w_ext = {{24{w_byte[7]}}, w_byte};
            c_RD_BYTE_U: w_ext = {24'h0, w_byte};
            default:     w_ext = w_ramQ;
        endcase
    end

    assign bus.readdataM = w_ext;
    assign bus.mem_stall = w_stall;
    assign bus.adelM     = w_adel;
    assign bus.adesM     = w_ades;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// =============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic setIdle();
        bus.memwriteM    = 1'b0;
        bus.memreadM     = 1'b0;
        bus.aluoutM      = 32'h0;
        bus.writedataM   = 32'h0;
        bus.DMwrite_ctrl = c_WR_NONE;
        bus.DMread_ctrl  = c_RD_WORD;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic doStore(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input logic alsoRead);
        bus.memwriteM    = 1'b1;
        bus.memreadM     = alsoRead;
        bus.aluoutM      = addr;
        bus.writedataM   = data;
        bus.DMwrite_ctrl = size;
        #3;
        checkVal({tag, "_stall"}, {31'b0, bus.mem_stall}, 32'd0);
        checkVal({tag, "_ades"},  {31'b0, bus.adesM},     32'd0);
        checkVal({tag, "_adel"},  {31'b0, bus.adelM},     32'd0);
        @(posedge clk);
        #1;
        setIdle();
    endtask

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] kind,
                          input logic [31:0] exp);
        bus.memreadM    = 1'b1;
        bus.aluoutM     = addr;
        bus.DMread_ctrl = kind;
        #3;
        checkVal({tag, "_stall1"}, {31'b0, bus.mem_stall}, 32'd1);
        @(posedge clk);
        #1;
        checkVal({tag, "_stall0"}, {31'b0, bus.mem_stall}, 32'd0);
        checkVal({tag, "_data"},   bus.readdataM,          exp);
        @(posedge clk);
        #1;
        setIdle();
        #1;
        checkVal({tag, "_hold"},   bus.readdataM,          exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        setIdle();
        rst = 1'b0;
        // A pending aligned load must not stall while reset is held.
        bus.memreadM = 1'b1;
        bus.aluoutM  = 32'h10;
        #2;
        checkVal("rst_data",  bus.readdataM,           32'h0);
        checkVal("rst_stall", {31'b0, bus.mem_stall},  32'd0);
        checkVal("rst_adel",  {31'b0, bus.adelM},      32'd0);
        checkVal("rst_ades",  {31'b0, bus.adesM},      32'd0);
        @(posedge clk);
        #1;
        setIdle();
        rst = 1'b1;

        doStore("sw10", 32'h10, 32'hDEADBEEF, c_WR_WORD, 1'b0);
        doLoad ("lw10", 32'h10, c_RD_WORD, 32'hDEADBEEF);

        doStore("sb13", 32'h13, 32'h00000080, c_WR_BYTE, 1'b0);
        doLoad ("lb13", 32'h13, c_RD_BYTE_S, 32'hFFFFFF80);
        doLoad ("lbu13", 32'h13, c_RD_BYTE_U, 32'h00000080);
        doLoad ("lw10b", 32'h10, c_RD_WORD, 32'h80ADBEEF);
        doLoad ("lbu11", 32'h11, c_RD_BYTE_U, 32'h000000BE);

        doStore("sw14", 32'h14, 32'hCAFEF00D, c_WR_WORD, 1'b0);
        doStore("sh16", 32'h16, 32'hFFFF1234, c_WR_HALF, 1'b0);
        doLoad ("lh16", 32'h16, c_RD_HALF_S, 32'h00001234);
        doLoad ("lw14", 32'h14, c_RD_WORD, 32'h1234F00D);
        doLoad ("lhs14", 32'h14, c_RD_HALF_S, 32'hFFFFF00D);
        doLoad ("lhu14", 32'h14, c_RD_HALF_U, 32'h0000F00D);

        // Misaligned word load: pulse, no stall, result register untouched.
        bus.memreadM    = 1'b1;
        bus.aluoutM     = 32'h22;
        bus.DMread_ctrl = c_RD_WORD;
        #3;
        checkVal("mis_lw_adel",  {31'b0, bus.adelM},     32'd1);
        checkVal("mis_lw_stall", {31'b0, bus.mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        setIdle();
        #1;
        checkVal("mis_lw_adel0", {31'b0, bus.adelM},     32'd0);
        checkVal("mis_lw_data",  bus.readdataM,          32'h0000F00D);

        doStore("sw20", 32'h20, 32'h11223344, c_WR_WORD, 1'b0);
        bus.memwriteM    = 1'b1;
        bus.aluoutM      = 32'h21;
        bus.writedataM   = 32'h0000FFFF;
        bus.DMwrite_ctrl = c_WR_HALF;
        #3;
        checkVal("mis_sh_ades",  {31'b0, bus.adesM},     32'd1);
        checkVal("mis_sh_stall", {31'b0, bus.mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        setIdle();
        #1;
        checkVal("mis_sh_ades0", {31'b0, bus.adesM},     32'd0);
        doLoad ("lw20", 32'h20, c_RD_WORD, 32'h11223344);

        doStore("rw30", 32'h30, 32'hA5A5A5A5, c_WR_WORD, 1'b1);
        doLoad ("lw30", 32'h30, c_RD_WORD, 32'hA5A5A5A5);

        doStore("nop10", 32'h10, 32'h00000000, c_WR_NONE, 1'b0);
        doLoad ("alias410", 32'h410, c_RD_WORD, 32'h80ADBEEF);

        // Reset during RD_DONE aborts the load immediately.
        doLoad ("pre_rst", 32'h16, c_RD_HALF_U, 32'h00001234);
        bus.memreadM    = 1'b1;
        bus.aluoutM     = 32'h30;
        bus.DMread_ctrl = c_RD_WORD;
        @(posedge clk);
        #1;
        checkVal("rd_done_data", bus.readdataM, 32'hA5A5A5A5);
        rst = 1'b0;
        #1;
        checkVal("midrst_data",  bus.readdataM,          32'h0);
        checkVal("midrst_stall", {31'b0, bus.mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        setIdle();
        rst = 1'b1;
        doLoad ("post_rst10", 32'h10, c_RD_WORD, 32'h80ADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-index width (2**ADDR_W 32-bit words of storage).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port memwriteM  input  1  store request from CPU memory stage.
REQ-005 SHALL have port memreadM  input  1  load request from CPU memory stage.
REQ-006 SHALL have port aluoutM  input  32  byte address.
REQ-007 SHALL have port writedataM  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port DMwrite_ctrl  input  2  store size: 00 word, 01 half, 10 byte, 11 no-op.
REQ-009 SHALL have port DMread_ctrl  input  3  load type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, others treated as word.
REQ-010 SHALL have port readdataM  output  32  extended, right-aligned load result.
REQ-011 SHALL have port mem_stall  output  1  CPU must hold memory-stage inputs stable while high.
REQ-012 SHALL have port adelM  output  1  load address misaligned (one-cycle pulse).
REQ-013 SHALL have port adesM  output  1  store address misaligned (one-cycle pulse).

Function
REQ-014 SHALL address storage with index aluoutM[ADDR_W+1:2]; bits above ignored (aliasing permitted).
REQ-015 SHALL implement FSM states IDLE and RD_DONE; IDLE->RD_DONE on accepted aligned load, RD_DONE->IDLE unconditionally next cycle.
REQ-016 SHALL assert mem_stall combinationally in IDLE when memreadM=1, memwriteM=0 and address aligned; mem_stall=0 in RD_DONE and all other cases.
REQ-017 SHALL read storage synchronously on the accepting edge; readdataM SHALL present extended data during RD_DONE (load latency 1 stall cycle, data valid in cycle N+1 for request in cycle N).
REQ-018 SHALL register readdataM and hold the last load result until the next completed load.
REQ-019 SHALL select byte lane aluoutM[1:0] and half lane aluoutM[1] for sub-word loads; signed types sign-extend bit 7/15, unsigned types zero-extend.
REQ-020 SHALL perform stores in one cycle without stall, writing only the byte lanes selected by size and aluoutM[1:0]; other lanes unchanged.
REQ-021 SHALL treat alignment as: word needs aluoutM[1:0]=00, half needs aluoutM[0]=0, byte always aligned.
REQ-022 SHALL suppress the access on misalignment (no write, no FSM transition, no stall) and pulse adelM or adesM for that cycle only.
REQ-023 SHALL treat memreadM and memwriteM both high as a store; load ignored, no stall, adelM never set.
REQ-024 SHALL make a store at edge N visible to a load accepted at edge N+1 or later (no bypass within same edge required).
REQ-025 SHALL ignore memreadM/memwriteM while in RD_DONE (request is the held one).

Reset
REQ-026 SHALL on rst=0 asynchronously force state IDLE, readdataM=0, adelM=0, adesM=0; mem_stall SHALL be 0 while rst=0.
REQ-027 SHALL abort an in-flight load on reset mid-operation; no write is performed during reset.
REQ-028 SHALL NOT reset storage contents (undefined until written).

Structure
REQ-029 SHALL place DMwrite_ctrl and DMread_ctrl encodings and FSM state encoding in the shared package alongside existing MIPS control constants.
REQ-030 SHALL use one sub-module, dmem_ram: byte-enabled synchronous single-port RAM, 4 write enables, registered read.
REQ-031 SHALL keep lane select, extension and alignment check in dmem_responder.

Verification
REQ-032 SHALL cover: store word 0xDEADBEEF to 0x10, load word 0x10 -> mem_stall high 1 cycle, readdataM=0xDEADBEEF next cycle.
REQ-033 SHALL cover: store byte 0x80 to 0x13, load byte signed 0x13 -> 0xFFFFFF80; byte unsigned -> 0x00000080; word 0x10 -> 0x80ADBEEF.
REQ-034 SHALL cover: store half 0x1234 to 0x16, load half signed 0x16 -> 0x00001234, word 0x14 -> 0x1234xxxx with low half unchanged.
REQ-035 SHALL cover: load word at 0x22 -> adelM pulse 1 cycle, mem_stall=0, readdataM unchanged; store half at 0x21 -> adesM pulse, memory unchanged.
REQ-036 SHALL cover: assert rst=0 during the RD_DONE cycle -> state IDLE, readdataM=0, mem_stall=0 immediately; memory contents at 0x10 preserved.
REQ-037 SHALL cover: memreadM=memwriteM=1 word at 0x30 with 0xA5A5A5A5 -> no stall, subsequent load 0x30 returns 0xA5A5A5A5.
